// File: rtl/icache_pkg.sv
// ============================================================================
// Module   : icache_pkg
// Purpose  : Shared widths and refill state encoding for the icache miss path.
// Revision : 1.0
// ============================================================================
`default_nettype none

package icache_pkg;

  localparam int INDEX_W  = 6;
  localparam int TAG_W    = 44;
  localparam int OFFSET_W = 6;
  localparam int WAYS     = 8;
  localparam int WAY_W    = 3;
  localparam int BEAT_W   = 64;
  localparam int BEATS    = 8;
  localparam int LINE_W   = 512;
  localparam int PADDR_W  = 56;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_FILL = 3'd3,
    ST_RESP = 3'd4
  } refill_state_e;

endpackage

`default_nettype wire

// File: rtl/icache_victim_sel.sv
// ============================================================================
// Module   : icache_victim_sel
// Purpose  : Victim way choice: lowest free way, else a round-robin pointer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module icache_victim_sel
  import icache_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             all_valid,
  input  logic [WAY_W-1:0] free_way,
  output logic [WAY_W-1:0] victim
);

  logic [WAY_W-1:0] r_rr_ptr;

  // Wraps naturally modulo WAYS since WAYS == 2**WAY_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (advance) begin
      r_rr_ptr <= r_rr_ptr + WAY_W'(1);
    end
  end

  assign victim = all_valid ? r_rr_ptr : free_way;

endmodule

`default_nettype wire

// File: rtl/icache_refill.sv
// ============================================================================
// Module   : icache_refill
// Purpose  : Single-outstanding icache miss engine: line or uncached word fetch.
// Revision : 1.0
// ============================================================================
`default_nettype none

module icache_refill
  import icache_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [INDEX_W-1:0]  req_index,
  input  logic [TAG_W-1:0]    req_ptag,
  input  logic [OFFSET_W-1:0] req_offset,
  input  logic                req_uncache,
  input  logic                req_all_valid,
  input  logic [WAY_W-1:0]    req_free_way,
  output logic                mem_ar_valid,
  input  logic                mem_ar_ready,
  output logic [PADDR_W-1:0]  mem_ar_addr,
  output logic [7:0]          mem_ar_len,
  input  logic                mem_r_valid,
  output logic                mem_r_ready,
  input  logic [BEAT_W-1:0]   mem_r_data,
  input  logic                mem_r_last,
  output logic                refill_wr_en,
  output logic [INDEX_W-1:0]  refill_wr_index,
  output logic [WAY_W-1:0]    refill_wr_way,
  output logic [TAG_W-1:0]    refill_wr_tag,
  output logic [LINE_W-1:0]   refill_wr_data,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [BEAT_W-1:0]   resp_data,
  output logic                resp_uncache
);

  refill_state_e       r_state;
  refill_state_e       w_next;
  logic [INDEX_W-1:0]  r_index;
  logic [TAG_W-1:0]    r_ptag;
  logic [2:0]          r_word;
  logic                r_uncache;
  logic [WAY_W-1:0]    r_way;
  logic [2:0]          r_beat_cnt;
  logic [BEAT_W-1:0]   r_line [BEATS];
  logic                w_accept;
  logic                w_advance;
  logic                w_beat;
  logic                w_last_beat;
  logic [WAY_W-1:0]    w_victim;

  assign w_accept    = (r_state == ST_IDLE) && req_valid;
  assign w_advance   = w_accept && !req_uncache && req_all_valid;
  assign w_beat      = (r_state == ST_DATA) && mem_r_valid;
  // The local beat count decides the end of a burst; mem_r_last is not trusted.
  assign w_last_beat = w_beat && (r_uncache || (r_beat_cnt == 3'(BEATS - 1)));

  icache_victim_sel u_victim_sel (
    .clk       (clk),
    .rst_n     (rst_n),
    .advance   (w_advance),
    .all_valid (req_all_valid),
    .free_way  (req_free_way),
    .victim    (w_victim)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (req_valid)    w_next = ST_ADDR;
      ST_ADDR: if (mem_ar_ready) w_next = ST_DATA;
      ST_DATA: if (w_last_beat)  w_next = r_uncache ? ST_RESP : ST_FILL;
      ST_FILL:                   w_next = ST_RESP;
      ST_RESP: if (resp_ready)   w_next = ST_IDLE;
      default:                   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready    = (r_state == ST_IDLE);
    mem_ar_valid = (r_state == ST_ADDR);
    mem_r_ready  = (r_state == ST_DATA);
    refill_wr_en = (r_state == ST_FILL);
    resp_valid   = (r_state == ST_RESP);
    mem_ar_len   = ((r_state == ST_ADDR) && !r_uncache) ? 8'(BEATS - 1) : 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_index    <= '0;
      r_ptag     <= '0;
      r_word     <= '0;
      r_uncache  <= 1'b0;
      r_way      <= '0;
      r_beat_cnt <= '0;
      for (int k = 0; k < BEATS; k++) begin
        r_line[k] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_index   <= req_index;
        r_ptag    <= req_ptag;
        r_word    <= req_offset[5:3];
        r_uncache <= req_uncache;
        r_way     <= w_victim;
      end
      if (w_beat) begin
        r_line[r_beat_cnt] <= mem_r_data;
        r_beat_cnt         <= w_last_beat ? 3'd0 : r_beat_cnt + 3'd1;
      end
    end
  end

  // Uncached fetches are word aligned; cached fetches are line aligned.
  assign mem_ar_addr = {r_ptag, r_index, (r_uncache ? r_word : 3'd0), 3'd0};

  assign refill_wr_index = r_index;
  assign refill_wr_way   = r_way;
  assign refill_wr_tag   = r_ptag;
  assign resp_uncache    = r_uncache;
  assign resp_data       = r_uncache ? r_line[0] : r_line[r_word];

  generate
    for (genvar k = 0; k < BEATS; k++) begin : g_line
      assign refill_wr_data[k*BEAT_W +: BEAT_W] = r_line[k];
    end
  endgenerate

endmodule

`default_nettype wire
